memory_access: RTL and testbench

Memory pipeline stage of the MIPS pipeline. It consumes the M-stage control and data from the execute stage's memory pipeline register and issues word loads and stores on a variable-latency data-memory request/grant/response bus. While an access is outstanding it stalls the pipeline, and it owns the writeback pipeline register that feeds the W stage and the forwarding path.

---
 rtl/mem_stage_pkg.sv | 28 ++
 rtl/writeback_reg.sv | 69 ++++++
 rtl/memory_access.sv | 178 +++++++++++++++++
 tb/tb_memory_access.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MIPS memory pipeline stage.
//   mem_state_e     : memory-access FSM states
//   ctrl_w_t        : W-stage control bundle carried by the writeback register
//   WORD_ALIGN_MASK : low address bits that must be zero for a word access
package mem_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } ctrl_w_t;

  // True when the byte address is word aligned.
  function automatic logic is_word_aligned(input logic [1:0] addr_lo);
    return (addr_lo & WORD_ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/writeback_reg.sv
// M/W pipeline register with stall-bubble insertion.
//   clk_i, rst_i   : clock, async active-high reset
//   stall_i        : hold data fields and emit a bubble (control cleared)
//   kill_i         : advance but retire as a bubble (aborted/misaligned access)
//   load_done_i    : capture rdata_i into the read-data field
//   ctrl_m_i, alu_out_m_i, write_reg_m_i, rdata_i : M-stage inputs
//   ctrl_w_o, alu_out_w_o, write_reg_w_o, read_data_w_o : W-stage outputs
module writeback_reg
  import mem_stage_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              kill_i,
  input  logic              load_done_i,
  input  ctrl_w_t           ctrl_m_i,
  input  logic [DATA_W-1:0] alu_out_m_i,
  input  logic [REG_W-1:0]  write_reg_m_i,
  input  logic [DATA_W-1:0] rdata_i,
  output ctrl_w_t           ctrl_w_o,
  output logic [DATA_W-1:0] alu_out_w_o,
  output logic [REG_W-1:0]  write_reg_w_o,
  output logic [DATA_W-1:0] read_data_w_o
);

  ctrl_w_t           ctrl_q, ctrl_d;
  logic [DATA_W-1:0] alu_out_q, alu_out_d;
  logic [REG_W-1:0]  write_reg_q, write_reg_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;

  // Next-state: advance when not stalled, otherwise bubble with data held.
  always_comb begin
    ctrl_d      = ctrl_q;
    alu_out_d   = alu_out_q;
    write_reg_d = write_reg_q;
    read_data_d = read_data_q;
    if (stall_i) begin
      ctrl_d = '0;
    end else begin
      ctrl_d      = kill_i ? ctrl_w_t'('0) : ctrl_m_i;
      alu_out_d   = alu_out_m_i;
      write_reg_d = write_reg_m_i;
      if (load_done_i) begin
        read_data_d = rdata_i;
      end
    end
  end

  // Register stage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q      <= '0;
      alu_out_q   <= '0;
      write_reg_q <= '0;
      read_data_q <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      alu_out_q   <= alu_out_d;
      write_reg_q <= write_reg_d;
      read_data_q <= read_data_d;
    end
  end

  assign ctrl_w_o      = ctrl_q;
  assign alu_out_w_o   = alu_out_q;
  assign write_reg_w_o = write_reg_q;
  assign read_data_w_o = read_data_q;

endmodule

// File: rtl/memory_access.sv
// MIPS memory pipeline stage: issues word loads/stores on a req/gnt/rvalid
// data bus, stalls the pipeline while an access is outstanding and owns the
// W pipeline register.
//   clk_i, rst_i          : clock, async active-high reset
//   *_m_i                 : M-stage control and data
//   dmem_*                : data-memory request/grant/response bus
//   stall_m_o             : hold F/D/E/M pipeline registers
//   *_w_o                 : W-stage pipeline register outputs
//   align_err_o           : one-cycle pulse on a misaligned access
//   timeout_o             : sticky bus-timeout flag
module memory_access
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              reg_write_m_i,
  input  logic              mem_write_m_i,
  input  logic              mem_to_reg_m_i,
  input  logic [DATA_W-1:0] alu_out_m_i,
  input  logic [DATA_W-1:0] write_data_m_i,
  input  logic [REG_W-1:0]  write_reg_m_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [DATA_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic              stall_m_o,
  output logic              reg_write_w_o,
  output logic              mem_to_reg_w_o,
  output logic [DATA_W-1:0] read_data_w_o,
  output logic [DATA_W-1:0] alu_out_w_o,
  output logic [REG_W-1:0]  write_reg_w_o,
  output logic              align_err_o,
  output logic              timeout_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             align_err_q, align_err_d;

  logic req_c, stall_c, kill_c, load_done_c;
  logic mem_op, is_store, aligned, timeout_hit;

  // Both store and load bits set is treated as a store.
  assign mem_op      = mem_write_m_i | mem_to_reg_m_i;
  assign is_store    = mem_write_m_i;
  assign aligned     = is_word_aligned(alu_out_m_i[1:0]);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Next-state and bus/stall decode.
  always_comb begin
    state_d     = state_q;
    timeout_d   = timeout_q;
    align_err_d = 1'b0;
    req_c       = 1'b0;
    stall_c     = 1'b0;
    kill_c      = 1'b0;
    load_done_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mem_op) begin
          if (!aligned) begin
            align_err_d = 1'b1;
            kill_c      = 1'b1;
          end else begin
            req_c = 1'b1;
            if (is_store) begin
              if (!dmem_gnt_i) begin
                state_d = REQ;
                stall_c = 1'b1;
              end
            end else begin
              state_d = dmem_gnt_i ? WAIT : REQ;
              stall_c = 1'b1;
            end
          end
        end
      end
      REQ: begin
        // Abort takes priority so the request never depends on gnt.
        if (timeout_hit) begin
          state_d   = IDLE;
          kill_c    = 1'b1;
          timeout_d = 1'b1;
        end else begin
          req_c = 1'b1;
          if (dmem_gnt_i && is_store) begin
            state_d = IDLE;
          end else begin
            stall_c = 1'b1;
            if (dmem_gnt_i) begin
              state_d = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (timeout_hit) begin
          state_d   = IDLE;
          kill_c    = 1'b1;
          timeout_d = 1'b1;
        end else if (dmem_rvalid_i) begin
          state_d     = IDLE;
          load_done_c = 1'b1;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Stalled-cycle counter; clears whenever the FSM returns to IDLE.
    if (state_d == IDLE || TIMEOUT_CYCLES == 0) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // FSM, counter and flag registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      align_err_q <= align_err_d;
    end
  end

  // Request and stall must drop the moment reset asserts, even with an M op present.
  assign dmem_req_o   = req_c & ~rst_i;
  assign stall_m_o    = stall_c & ~rst_i;
  assign dmem_we_o    = mem_write_m_i;
  assign dmem_addr_o  = alu_out_m_i;
  assign dmem_wdata_o = write_data_m_i;
  assign align_err_o  = align_err_q;
  assign timeout_o    = timeout_q;

  ctrl_w_t ctrl_m, ctrl_w;

  assign ctrl_m.reg_write  = reg_write_m_i;
  assign ctrl_m.mem_to_reg = mem_to_reg_m_i;

  writeback_reg u_writeback_reg (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .stall_i       (stall_c),
    .kill_i        (kill_c),
    .load_done_i   (load_done_c),
    .ctrl_m_i      (ctrl_m),
    .alu_out_m_i   (alu_out_m_i),
    .write_reg_m_i (write_reg_m_i),
    .rdata_i       (dmem_rdata_i),
    .ctrl_w_o      (ctrl_w),
    .alu_out_w_o   (alu_out_w_o),
    .write_reg_w_o (write_reg_w_o),
    .read_data_w_o (read_data_w_o)
  );

  assign reg_write_w_o  = ctrl_w.reg_write;
  assign mem_to_reg_w_o = ctrl_w.mem_to_reg;

endmodule

// File: tb/tb_memory_access.sv
// Directed and randomized checks of the memory pipeline stage against a
// transaction-level model (stall length and W-register contents per access).
module tb_memory_access;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        reg_write_m_i = 1'b0;
  logic        mem_write_m_i = 1'b0;
  logic        mem_to_reg_m_i = 1'b0;
  logic [31:0] alu_out_m_i = '0;
  logic [31:0] write_data_m_i = '0;
  logic [4:0]  write_reg_m_i = '0;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i = 1'b0;
  logic        dmem_rvalid_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic        stall_m_o;
  logic        reg_write_w_o;
  logic        mem_to_reg_w_o;
  logic [31:0] read_data_w_o;
  logic [31:0] alu_out_w_o;
  logic [4:0]  write_reg_w_o;
  logic        align_err_o;
  logic        timeout_o;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_rd = '0;

  always #5 clk_i = ~clk_i;

  memory_access #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .reg_write_m_i  (reg_write_m_i),
    .mem_write_m_i  (mem_write_m_i),
    .mem_to_reg_m_i (mem_to_reg_m_i),
    .alu_out_m_i    (alu_out_m_i),
    .write_data_m_i (write_data_m_i),
    .write_reg_m_i  (write_reg_m_i),
    .dmem_req_o     (dmem_req_o),
    .dmem_we_o      (dmem_we_o),
    .dmem_addr_o    (dmem_addr_o),
    .dmem_wdata_o   (dmem_wdata_o),
    .dmem_gnt_i     (dmem_gnt_i),
    .dmem_rvalid_i  (dmem_rvalid_i),
    .dmem_rdata_i   (dmem_rdata_i),
    .stall_m_o      (stall_m_o),
    .reg_write_w_o  (reg_write_w_o),
    .mem_to_reg_w_o (mem_to_reg_w_o),
    .read_data_w_o  (read_data_w_o),
    .alu_out_w_o    (alu_out_w_o),
    .write_reg_w_o  (write_reg_w_o),
    .align_err_o    (align_err_o),
    .timeout_o      (timeout_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_m(input logic rw, input logic mw, input logic mr,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] wr);
    reg_write_m_i  = rw;
    mem_write_m_i  = mw;
    mem_to_reg_m_i = mr;
    alu_out_m_i    = addr;
    write_data_m_i = wd;
    write_reg_m_i  = wr;
  endtask

  task automatic set_bus(input logic g, input logic v, input logic [31:0] d);
    dmem_gnt_i    = g;
    dmem_rvalid_i = v;
    dmem_rdata_i  = d;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".req"},   32'(dmem_req_o), 0);
    check({tag, ".stall"}, 32'(stall_m_o), 0);
    check({tag, ".rw_w"},  32'(reg_write_w_o), 0);
    check({tag, ".m2r_w"}, 32'(mem_to_reg_w_o), 0);
    check({tag, ".rd_w"},  read_data_w_o, 0);
    check({tag, ".alu_w"}, alu_out_w_o, 0);
    check({tag, ".wr_w"},  32'(write_reg_w_o), 0);
    check({tag, ".aerr"},  32'(align_err_o), 0);
    check({tag, ".tmo"},   32'(timeout_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned kind, gd, rd, stall_total;
    logic        rw, mw, mr, mem, aligned, is_load, noise;
    logic [31:0] addr, wd, rdata, tmp;
    logic [4:0]  wr;

    // Reset with a load present on M: request and stall must stay low.
    set_m(1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 5'd3);
    #12;
    check_all_zero("reset");
    set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1 rst_i = 1'b0;
    tick();

    // Store with same-cycle grant: single request cycle, no stall.
    set_m(1'b0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 5'd0);
    set_bus(1'b1, 1'b0, 32'h0);
    #1;
    check("st.req", 32'(dmem_req_o), 1);
    check("st.we", 32'(dmem_we_o), 1);
    check("st.addr", dmem_addr_o, 32'h100);
    check("st.wdata", dmem_wdata_o, 32'hDEADBEEF);
    check("st.stall", 32'(stall_m_o), 0);
    tick();
    set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    set_bus(1'b0, 1'b0, 32'h0);
    #1;
    check("st.req_after", 32'(dmem_req_o), 0);
    check("st.alu_w", alu_out_w_o, 32'h100);

    // Load with gnt at cycle 0 and rvalid at cycle 3.
    set_m(1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 5'd5);
    for (int c = 0; c <= 3; c++) begin
      set_bus(c == 0, c == 3, (c == 3) ? 32'h12345678 : 32'h0);
      #1;
      check($sformatf("ld.stall%0d", c), 32'(stall_m_o), (c < 3) ? 1 : 0);
      check($sformatf("ld.req%0d", c), 32'(dmem_req_o), (c == 0) ? 1 : 0);
      tick();
    end
    exp_rd = 32'h12345678;
    check("ld.rd_w", read_data_w_o, exp_rd);
    check("ld.m2r_w", 32'(mem_to_reg_w_o), 1);
    check("ld.rw_w", 32'(reg_write_w_o), 1);
    check("ld.wr_w", 32'(write_reg_w_o), 5);

    // Load with grant withheld for 4 cycles.
    set_m(1'b1, 1'b0, 1'b1, 32'h304, 32'h0, 5'd7);
    for (int c = 0; c <= 5; c++) begin
      set_bus(c == 4, c == 5, (c == 5) ? 32'hA5A50F0F : 32'h0);
      #1;
      check($sformatf("gw.stall%0d", c), 32'(stall_m_o), (c < 5) ? 1 : 0);
      check($sformatf("gw.req%0d", c), 32'(dmem_req_o), (c <= 4) ? 1 : 0);
      if (c <= 4) check($sformatf("gw.addr%0d", c), dmem_addr_o, 32'h304);
      tick();
      if (c < 5) check($sformatf("gw.rw_w%0d", c), 32'(reg_write_w_o), 0);
    end
    exp_rd = 32'hA5A50F0F;
    check("gw.rd_w", read_data_w_o, exp_rd);
    check("gw.rw_w", 32'(reg_write_w_o), 1);

    // Misaligned store: no request, no stall, one align_err pulse, bubble.
    set_m(1'b1, 1'b1, 1'b0, 32'h102, 32'h55AA55AA, 5'd9);
    set_bus(1'b0, 1'b0, 32'h0);
    #1;
    check("mis.req", 32'(dmem_req_o), 0);
    check("mis.stall", 32'(stall_m_o), 0);
    check("mis.aerr_pre", 32'(align_err_o), 0);
    tick();
    check("mis.aerr", 32'(align_err_o), 1);
    check("mis.rw_w", 32'(reg_write_w_o), 0);
    set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();
    check("mis.aerr_once", 32'(align_err_o), 0);
    check("mis.rd_hold", read_data_w_o, exp_rd);

    // Randomized transactions: 0 alu, 1 load, 2 store, 3/4 misaligned load/store, 5 load+store.
    for (int t = 0; t < 40; t++) begin
      kind    = $urandom_range(0, 5);
      gd      = $urandom_range(0, 3);
      rd      = $urandom_range(1, 3);
      rdata   = $urandom();
      wd      = $urandom();
      wr      = 5'($urandom_range(0, 31));
      rw      = 1'($urandom_range(0, 1));
      tmp     = $urandom();
      addr    = tmp & 32'hFFFF_FFFC;
      if (kind == 3 || kind == 4) addr = addr | 32'($urandom_range(1, 3));
      mw      = (kind == 2 || kind == 4 || kind == 5);
      mr      = (kind == 1 || kind == 3 || kind == 5);
      mem     = (kind != 0);
      aligned = !(kind == 3 || kind == 4);
      is_load = (kind == 1);
      stall_total = (!mem || !aligned) ? 0 : (is_load ? gd + rd : gd);
      set_m(rw, mw, mr, addr, wd, wr);
      for (int unsigned c = 0; c <= stall_total; c++) begin
        noise = 1'($urandom_range(0, 1));
        tmp   = $urandom();
        if (is_load && c == gd + rd)
          set_bus(1'b0, 1'b1, rdata);
        else if (mem && aligned && c == gd)
          set_bus(1'b1, 1'b0, tmp);
        else if (mem && aligned && c > gd)
          set_bus(1'b0, 1'b0, tmp);
        else
          set_bus(1'b0, noise, tmp);
        #1;
        check($sformatf("rnd%0d.stall%0d", t, c), 32'(stall_m_o), (c < stall_total) ? 1 : 0);
        check($sformatf("rnd%0d.req%0d", t, c), 32'(dmem_req_o), (mem && aligned && c <= gd) ? 1 : 0);
        if (mem && aligned && c <= gd) begin
          check($sformatf("rnd%0d.addr%0d", t, c), dmem_addr_o, addr);
          check($sformatf("rnd%0d.we%0d", t, c), 32'(dmem_we_o), 32'(mw));
        end
        tick();
        check($sformatf("rnd%0d.aerr%0d", t, c), 32'(align_err_o),
              (c == stall_total && mem && !aligned) ? 1 : 0);
        if (c < stall_total) check($sformatf("rnd%0d.bubble%0d", t, c), 32'(reg_write_w_o), 0);
      end
      if (is_load) exp_rd = rdata;
      check($sformatf("rnd%0d.rw_w", t), 32'(reg_write_w_o), (rw && aligned) ? 1 : 0);
      if (kind != 5) check($sformatf("rnd%0d.m2r_w", t), 32'(mem_to_reg_w_o), (mr && aligned) ? 1 : 0);
      if (aligned) begin
        check($sformatf("rnd%0d.alu_w", t), alu_out_w_o, addr);
        check($sformatf("rnd%0d.wr_w", t), 32'(write_reg_w_o), 32'(wr));
      end
      check($sformatf("rnd%0d.rd_w", t), read_data_w_o, exp_rd);
    end
    set_bus(1'b0, 1'b0, 32'h0);
    check("rnd.tmo", 32'(timeout_o), 0);

    // Load never granted: 8 stalled cycles, then release as a bubble.
    set_m(1'b1, 1'b0, 1'b1, 32'h400, 32'h0, 5'd4);
    for (int c = 0; c <= 8; c++) begin
      #1;
      check($sformatf("tmo.stall%0d", c), 32'(stall_m_o), (c < 8) ? 1 : 0);
      if (c == 8) check("tmo.req_abort", 32'(dmem_req_o), 0);
      tick();
    end
    check("tmo.flag", 32'(timeout_o), 1);
    check("tmo.rw_w", 32'(reg_write_w_o), 0);
    set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    set_bus(1'b0, 1'b1, 32'hFFFF0000);
    #1;
    check("tmo.late_stall", 32'(stall_m_o), 0);
    tick();
    set_bus(1'b0, 1'b0, 32'h0);
    check("tmo.late_rd", read_data_w_o, exp_rd);
    check("tmo.sticky", 32'(timeout_o), 1);
    tick();
    check("tmo.sticky2", 32'(timeout_o), 1);

    // Reset while a load waits for rvalid.
    set_m(1'b1, 1'b0, 1'b1, 32'h500, 32'h0, 5'd6);
    set_bus(1'b1, 1'b0, 32'h0);
    tick();
    set_bus(1'b0, 1'b0, 32'h0);
    #1;
    check("rstw.stall_pre", 32'(stall_m_o), 1);
    #1 rst_i = 1'b1;
    #1;
    check_all_zero("rstw");
    exp_rd = '0;
    set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1 rst_i = 1'b0;
    tick();
    set_m(1'b1, 1'b0, 1'b1, 32'h600, 32'h0, 5'd8);
    set_bus(1'b1, 1'b0, 32'h0);
    #1;
    check("post.stall0", 32'(stall_m_o), 1);
    tick();
    set_bus(1'b0, 1'b1, 32'hCAFEF00D);
    #1;
    check("post.stall1", 32'(stall_m_o), 0);
    tick();
    set_bus(1'b0, 1'b0, 32'h0);
    check("post.rd_w", read_data_w_o, 32'hCAFEF00D);
    check("post.rw_w", 32'(reg_write_w_o), 1);
    check("post.wr_w", 32'(write_reg_w_o), 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
